rnl_neuron_column: RTL and testbench
====================================

Name: rnl_neuron_column

Overview:
Column of NUM_OUTPUTS ramp-no-leak (RNL) excitatory neurons driven by NUM_INPUTS temporally-coded spike lines.
- Each neuron sums per-synapse ramp responses and fires one PULSE_WIDTH-cycle pulse per gamma cycle when its body potential reaches THRESHOLD.
- Output bus feeds wta_1.input_spikes directly; both blocks use the same GAMMA_CYCLE_WIDTH and PULSE_WIDTH.

Parameters:
- NUM_INPUTS, 8, number of input spike lines (synapses per neuron).
- NUM_OUTPUTS, 8, number of neurons; width of output_spikes.
- GAMMA_CYCLE_WIDTH, 16, clock cycles per gamma cycle.
- PULSE_WIDTH, 8, output pulse length in cycles; must be <= GAMMA_CYCLE_WIDTH.
- WEIGHT_WIDTH, 3, synaptic weight width; weights range 0..2^WEIGHT_WIDTH-1.
- THRESHOLD, 8, firing threshold for body potential.
- INIT_WEIGHT, 0, value loaded into every weight on reset.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- input_spikes  in  NUM_INPUTS  spike lines; a rising edge marks the spike time.
- wr_en  in  1  weight write strobe.
- wr_neuron  in  $clog2(NUM_OUTPUTS)  target neuron index.
- wr_synapse  in  $clog2(NUM_INPUTS)  target synapse index.
- wr_data  in  WEIGHT_WIDTH  new weight.
- output_spikes  out  NUM_OUTPUTS  registered spike pulses, one bit per neuron; goes to wta_1.
- gamma_start  out  1  high during cycle 0 of each gamma cycle.

Behaviour:
- Reset (async, rst=1):
  - gamma counter=0, in_prev=0, arrived=0, all ramps=0, fired=0, pulse counters=0.
  - output_spikes=0, gamma_start=1, all weights=INIT_WEIGHT.
- Gamma counter g:
  - counts 0..GAMMA_CYCLE_WIDTH-1 and wraps.
  - gamma_start=(g==0), combinational from g.
- Boundary edge (g==GAMMA_CYCLE_WIDTH-1):
  - clears arrived, ramps, fired, pulse counters and output_spikes.
  - clear wins over every other update on the same edge.
  - an input rise sampled on the boundary edge is dropped; in_prev still updates.
- Edge detect:
  - rise[i] = input_spikes[i] & ~in_prev[i]; in_prev updates every edge.
  - on a rise, arrived[i] sets and stays set until the boundary.
  - later rises on the same line within the gamma cycle are ignored.
- Ramp:
  - ramp[j][i] (WEIGHT_WIDTH bits) increments by 1 on each edge after the one that set arrived[i], while ramp[j][i] < w[j][i].
  - ramp saturates at the weight (no leak, no decrement).
  - weight 0 means the synapse contributes nothing.
- Potential:
  - pot[j] = sum over i of ramp[j][i], combinational.
  - width $clog2(NUM_INPUTS*(2^WEIGHT_WIDTH-1)+1); no overflow possible.
- Fire:
  - on an edge where pot[j] >= THRESHOLD and fired[j]=0: set fired[j], set output_spikes[j]=1, load pulse counter with PULSE_WIDTH.
  - output stays high exactly PULSE_WIDTH cycles, or is truncated at the boundary.
  - at most one pulse per neuron per gamma cycle.
  - neurons are independent; several may fire on the same edge (wta_1 arbitrates).
- Latency: input rise sampled at edge t, weight w >= THRESHOLD, single active synapse → output_spikes high after edge t+THRESHOLD+1.
- Weight write:
  - on an edge with wr_en=1, w[wr_neuron][wr_synapse] <= wr_data.
  - takes effect for ramp comparison from the next edge.
  - a ramp already above the new weight holds its value (no decrement).
  - out-of-range indices are ignored.
  - writes are accepted in any gamma phase.
- Reset mid-gamma: all state clears asynchronously, including weights; counting restarts at g=0.

Optional Feature:
- Macro: EXT_GAMMA_EN.
- Defined:
  - adds input port gamma_clr (1 bit).
  - internal counter removed; the boundary edge is any edge with gamma_clr=1.
  - gamma_start is the registered gamma_clr, high the cycle after the boundary edge.
- Undefined: internal counter as above; no gamma_clr port.

Test Plan:
- Single synapse: w[0][0]=7, THRESHOLD=4, rise on input 0 at edge 2 → output_spikes=8'h01 from edge 7 for 8 cycles; all other bits 0.
- Multi-synapse sum: w[3][1]=w[3][5]=4, THRESHOLD=8, rises on inputs 1 and 5 at the same edge t → bit 3 high after edge t+5; with only input 1 active, no spike.
- Once-per-gamma: sustained pot>=THRESHOLD, second rise on the same line → exactly one 8-cycle pulse; after the boundary, new rise at g=1 → fires again.
- Boundary: rise sampled at g=15 → ignored; pulse started at g=12 → truncated, output 0 at g=0.
- Simultaneous fire: neurons 2 and 6 with identical weights/inputs → output_spikes=8'h44 on the same cycle.
- Async reset mid-pulse: rst asserted between edges → output_spikes=0 and gamma_start=1 immediately; weights read back as INIT_WEIGHT behaviour (no fire with INIT_WEIGHT=0).

Source files
------------

// File: rtl/rnl_neuron_column.sv
// Column of ramp-no-leak neurons fed by temporally coded spike lines; one pulse per neuron per gamma cycle.
// Optional macro EXT_GAMMA_EN: gamma boundary comes from the gamma_clr port instead of the internal counter.

module rnl_neuron #(
  parameter int NUM_INPUTS   = 8,
  parameter int WEIGHT_WIDTH = 3,
  parameter int THRESHOLD    = 8,
  parameter int PULSE_WIDTH  = 8,
  parameter int INIT_WEIGHT  = 0,
  parameter int SYN_W        = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    boundary,
  input  logic [NUM_INPUTS-1:0]   arrived,
  input  logic                    wr_en,
  input  logic [SYN_W-1:0]        wr_synapse,
  input  logic [WEIGHT_WIDTH-1:0] wr_data,
  output logic                    spike
);
  localparam int POT_W = $clog2(NUM_INPUTS * ((1 << WEIGHT_WIDTH) - 1) + 1);
  localparam int CNT_W = $clog2(PULSE_WIDTH + 1);

  logic [NUM_INPUTS-1:0][WEIGHT_WIDTH-1:0] w_q, w_d, ramp_q, ramp_d;
  logic [POT_W-1:0] pot;
  logic             fired_q, fired_d, spike_q, spike_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    pot = '0;
    for (int i = 0; i < NUM_INPUTS; i++) pot = pot + POT_W'(ramp_q[i]);
  end

  // Writes land in w_q, so the ramp compares against the new weight from the next edge on.
  always_comb begin
    w_d = w_q;
    for (int i = 0; i < NUM_INPUTS; i++)
      if (wr_en && (wr_synapse == SYN_W'(i))) w_d[i] = wr_data;
  end

  always_comb begin
    ramp_d  = ramp_q;
    fired_d = fired_q;
    spike_d = spike_q;
    cnt_d   = cnt_q;
    // A ramp above a freshly lowered weight simply stops; there is no leak.
    for (int i = 0; i < NUM_INPUTS; i++)
      if (arrived[i] && (ramp_q[i] < w_q[i])) ramp_d[i] = ramp_q[i] + WEIGHT_WIDTH'(1);
    if (spike_q) begin
      if (cnt_q <= CNT_W'(1)) begin
        spike_d = 1'b0;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
    if (!fired_q && (32'(pot) >= 32'(THRESHOLD))) begin
      fired_d = 1'b1;
      spike_d = 1'b1;
      cnt_d   = CNT_W'(PULSE_WIDTH);
    end
    if (boundary) begin
      ramp_d  = '0;
      fired_d = 1'b0;
      spike_d = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q     <= {NUM_INPUTS{WEIGHT_WIDTH'(INIT_WEIGHT)}};
      ramp_q  <= '0;
      fired_q <= 1'b0;
      spike_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      w_q     <= w_d;
      ramp_q  <= ramp_d;
      fired_q <= fired_d;
      spike_q <= spike_d;
      cnt_q   <= cnt_d;
    end
  end

  assign spike = spike_q;
endmodule

module rnl_neuron_column #(
  parameter int NUM_INPUTS        = 8,
  parameter int NUM_OUTPUTS       = 8,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int WEIGHT_WIDTH      = 3,
  parameter int THRESHOLD         = 8,
  parameter int INIT_WEIGHT       = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_INPUTS-1:0]          input_spikes,
  input  logic                           wr_en,
  input  logic [$clog2(NUM_OUTPUTS)-1:0] wr_neuron,
  input  logic [$clog2(NUM_INPUTS)-1:0]  wr_synapse,
  input  logic [WEIGHT_WIDTH-1:0]        wr_data,
`ifdef EXT_GAMMA_EN
  input  logic                           gamma_clr,
`endif
  output logic [NUM_OUTPUTS-1:0]         output_spikes,
  output logic                           gamma_start
);
  localparam int NEU_W = $clog2(NUM_OUTPUTS);
  localparam int SYN_W = $clog2(NUM_INPUTS);

  logic                  boundary;
  logic [NUM_INPUTS-1:0] in_prev_q, in_prev_d, arrived_q, arrived_d, rise;

`ifdef EXT_GAMMA_EN
  logic gamma_start_q, gamma_start_d;

  assign boundary      = gamma_clr;
  assign gamma_start_d = gamma_clr;
  assign gamma_start   = gamma_start_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) gamma_start_q <= 1'b1;
    else     gamma_start_q <= gamma_start_d;
  end
`else
  localparam int G_W = (GAMMA_CYCLE_WIDTH > 1) ? $clog2(GAMMA_CYCLE_WIDTH) : 1;
  logic [G_W-1:0] g_q, g_d;

  assign boundary    = (g_q == G_W'(GAMMA_CYCLE_WIDTH - 1));
  assign g_d         = boundary ? '0 : g_q + G_W'(1);
  assign gamma_start = (g_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) g_q <= '0;
    else     g_q <= g_d;
  end
`endif

  // First rise per line per gamma cycle latches arrival; a rise on the boundary edge is lost.
  always_comb begin
    rise      = input_spikes & ~in_prev_q;
    in_prev_d = input_spikes;
    arrived_d = boundary ? '0 : (arrived_q | rise);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_prev_q <= '0;
      arrived_q <= '0;
    end else begin
      in_prev_q <= in_prev_d;
      arrived_q <= arrived_d;
    end
  end

  for (genvar j = 0; j < NUM_OUTPUTS; j++) begin : g_neuron
    rnl_neuron #(
      .NUM_INPUTS  (NUM_INPUTS),
      .WEIGHT_WIDTH(WEIGHT_WIDTH),
      .THRESHOLD   (THRESHOLD),
      .PULSE_WIDTH (PULSE_WIDTH),
      .INIT_WEIGHT (INIT_WEIGHT),
      .SYN_W       (SYN_W)
    ) u_neuron (
      .clk       (clk),
      .rst       (rst),
      .boundary  (boundary),
      .arrived   (arrived_q),
      .wr_en     (wr_en && (wr_neuron == NEU_W'(j))),
      .wr_synapse(wr_synapse),
      .wr_data   (wr_data),
      .spike     (output_spikes[j])
    );
  end
endmodule

// File: tb/tb_rnl_neuron_column.sv
// Directed bench for rnl_neuron_column: default instance (THRESHOLD=8) plus a THRESHOLD=4 instance sharing stimulus.
module tb_rnl_neuron_column;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] input_spikes;
  logic       wr_en;
  logic [2:0] wr_neuron, wr_synapse, wr_data;
  logic [7:0] out8, out4;
  logic       gs8, gs4;
  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  rnl_neuron_column dut (
    .clk(clk), .rst(rst), .input_spikes(input_spikes), .wr_en(wr_en),
    .wr_neuron(wr_neuron), .wr_synapse(wr_synapse), .wr_data(wr_data),
    .output_spikes(out8), .gamma_start(gs8)
  );

  rnl_neuron_column #(.THRESHOLD(4)) dut_t4 (
    .clk(clk), .rst(rst), .input_spikes(input_spikes), .wr_en(wr_en),
    .wr_neuron(wr_neuron), .wr_synapse(wr_synapse), .wr_data(wr_data),
    .output_spikes(out4), .gamma_start(gs4)
  );

  task automatic do_reset;
    rst = 1'b1; input_spikes = '0; wr_en = 1'b0;
    wr_neuron = '0; wr_synapse = '0; wr_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_w(input int n, input int s, input int d);
    wr_en = 1'b1; wr_neuron = 3'(n); wr_synapse = 3'(s); wr_data = 3'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Leaves the bench at a negedge where the internal gamma phase is 0.
  task automatic sync_g0;
    int n = 0;
    while (gs8 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (gs8 !== 1'b1) begin
      fails++;
      $display("FAIL sync_g0: gamma_start=%b after %0d cycles, required 1", gs8, n);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; input_spikes = '0; wr_en = 1'b0;
    wr_neuron = '0; wr_synapse = '0; wr_data = '0;
    @(negedge clk);
    checks++; if (out8 !== 8'h00) begin fails++; $display("FAIL reset_out: got %h required 00", out8); end
    checks++; if (out4 !== 8'h00) begin fails++; $display("FAIL reset_out_t4: got %h required 00", out4); end
    checks++; if (gs8 !== 1'b1) begin fails++; $display("FAIL reset_gamma_start: got %b required 1", gs8); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_synapse;
    logic [7:0] exp;
    do_reset();
    write_w(0, 0, 7);
    sync_g0();
    repeat (2) @(negedge clk);
    input_spikes = 8'h01;
    for (int c = 3; c <= 16; c++) begin
      @(negedge clk);
      exp = (c >= 8 && c <= 15) ? 8'h01 : 8'h00;
      checks++;
      if (out4 !== exp) begin fails++; $display("FAIL single_t4 g=%0d: got %h required %h", c % 16, out4, exp); end
      checks++;
      if (out8 !== 8'h00) begin fails++; $display("FAIL single_th8 g=%0d: got %h required 00", c % 16, out8); end
    end
    input_spikes = '0;
  endtask

  task automatic test_multi_synapse;
    logic [7:0] exp;
    do_reset();
    write_w(3, 1, 4);
    write_w(3, 5, 4);
    sync_g0();
    input_spikes = 8'h02;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 1) input_spikes = '0;
      checks++;
      if (out8 !== 8'h00) begin fails++; $display("FAIL multi_one_input g=%0d: got %h required 00", c, out8); end
    end
    @(negedge clk);
    input_spikes = 8'h22;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      exp = (c >= 6 && c <= 13) ? 8'h08 : 8'h00;
      checks++;
      if (out8 !== exp) begin fails++; $display("FAIL multi_sum g=%0d: got %h required %h", c, out8, exp); end
    end
    input_spikes = '0;
  endtask

  task automatic test_once_per_gamma;
    logic [7:0] exp;
    do_reset();
    write_w(0, 0, 4);
    write_w(0, 1, 4);
    sync_g0();
    input_spikes = 8'h03;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      exp = (c >= 6 && c <= 13) ? 8'h01 : 8'h00;
      checks++;
      if (out8 !== exp) begin fails++; $display("FAIL once_first g=%0d: got %h required %h", c, out8, exp); end
      if (c == 7) input_spikes = 8'h00;
      if (c == 8) input_spikes = 8'h03;
    end
    input_spikes = 8'h00;
    for (int g = 0; g <= 15; g++) begin
      @(negedge clk);
      exp = (g >= 7 && g <= 14) ? 8'h01 : 8'h00;
      checks++;
      if (out8 !== exp) begin fails++; $display("FAIL once_next g=%0d: got %h required %h", g, out8, exp); end
      if (g == 1) input_spikes = 8'h03;
    end
    input_spikes = '0;
  endtask

  task automatic test_boundary;
    logic [7:0] exp;
    do_reset();
    write_w(0, 0, 4);
    write_w(0, 1, 4);
    sync_g0();
    repeat (15) @(negedge clk);
    input_spikes = 8'h03;
    for (int g = 0; g <= 15; g++) begin
      @(negedge clk);
      checks++;
      if (out8 !== 8'h00) begin fails++; $display("FAIL boundary_drop g=%0d: got %h required 00", g, out8); end
      checks++;
      if (gs8 !== (g == 0)) begin fails++; $display("FAIL gamma_start g=%0d: got %b required %b", g, gs8, (g == 0)); end
    end
    input_spikes = 8'h00;
    repeat (8) @(negedge clk);
    input_spikes = 8'h03;
    for (int c = 8; c <= 18; c++) begin
      @(negedge clk);
      exp = (c >= 13 && c <= 15) ? 8'h01 : 8'h00;
      checks++;
      if (out8 !== exp) begin fails++; $display("FAIL boundary_trunc g=%0d: got %h required %h", c % 16, out8, exp); end
    end
    input_spikes = '0;
  endtask

  task automatic test_simultaneous;
    logic [7:0] exp;
    do_reset();
    write_w(2, 0, 4);
    write_w(2, 1, 4);
    write_w(6, 0, 4);
    write_w(6, 1, 4);
    sync_g0();
    input_spikes = 8'h03;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      exp = (c >= 6 && c <= 13) ? 8'h44 : 8'h00;
      checks++;
      if (out8 !== exp) begin fails++; $display("FAIL simultaneous g=%0d: got %h required %h", c, out8, exp); end
    end
    input_spikes = '0;
  endtask

  task automatic test_async_reset;
    do_reset();
    write_w(0, 0, 4);
    write_w(0, 1, 4);
    sync_g0();
    input_spikes = 8'h03;
    repeat (8) @(negedge clk);
    checks++;
    if (out8 !== 8'h01) begin fails++; $display("FAIL pre_reset_pulse: got %h required 01", out8); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out8 !== 8'h00) begin fails++; $display("FAIL async_reset_out: got %h required 00", out8); end
    checks++;
    if (gs8 !== 1'b1) begin fails++; $display("FAIL async_reset_gamma_start: got %b required 1", gs8); end
    @(negedge clk);
    rst = 1'b0;
    input_spikes = 8'h00;
    @(negedge clk);
    input_spikes = 8'h03;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (out8 !== 8'h00) begin fails++; $display("FAIL post_reset_weights cyc=%0d: got %h required 00", c, out8); end
      checks++;
      if (out4 !== 8'h00) begin fails++; $display("FAIL post_reset_weights_t4 cyc=%0d: got %h required 00", c, out4); end
    end
    input_spikes = '0;
  endtask

  initial begin
    test_reset();
    test_single_synapse();
    test_multi_synapse();
    test_once_per_gamma();
    test_boundary();
    test_simultaneous();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
